// File: rtl/fp32_pkg.sv
// Shared binary32 definitions for the floating-point adder blocks.
// Holds the field layout, exponent bias, canonical special encodings,
// the default add latency and the operand classification helper.
package fp32_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int BIAS   = 127;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  localparam int ADD_LATENCY_DEF = 5;

  typedef enum logic [1:0] {
    ZERO,
    NORM,
    INF,
    NAN
  } fp_class_e;

  typedef struct packed {
    logic [SIGN_W-1:0] sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

  // Exponent zero covers both true zeros and subnormals; the adder flushes
  // subnormals, so they classify as ZERO.
  function automatic fp_class_e fp_classify(input fp32_t x);
    if (x.exp == '0) return ZERO;
    if (x.exp == '1) return (x.mant == '0) ? INF : NAN;
    return NORM;
  endfunction

endpackage

// File: rtl/fp32_add_timed_op_timer.sv
// op_timer: completion timer for a single in-flight operation.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   clk_en       advance enable; the count freezes while low
//   start        begin an operation (accepted only when not busy)
//   max          number of enabled edges from start to completion
//   busy         an operation is in flight
//   done         one-cycle pulse after the completing edge
//   fire         combinational: the current edge is the completing edge
module op_timer
  import fp32_pkg::*;
#(
  parameter int CNT_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] max,
  output logic                 busy,
  output logic                 done,
  output logic                 fire
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt;

  assign fire = clk_en && busy && ((cnt + CNT_ONE) == max);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      // done follows fire by one edge and drops on the next, even when stalled
      done <= fire;
      if (clk_en) begin
        if (!busy && start) begin
          busy <= 1'b1;
          cnt  <= CNT_ONE;
        end else if (busy) begin
          if (fire) begin
            busy <= 1'b0;
            cnt  <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
      end
    end
  end

endmodule

// File: rtl/fp32_add_timed.sv
// fp32_add_timed: five-stage binary32 adder with a completion timer.
// The caller pulses start with operands, waits for done, then samples result.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   clk_en          pipeline/timer advance enable
//   start           begin an operation; dataa/datab sampled on the same edge
//   dataa, datab    binary32 operands
//   result          registered sum, held until the next completion
//   done            one-cycle pulse: result is valid
//   busy            an operation is in flight
module fp32_add_timed
  import fp32_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADD_LATENCY = ADD_LATENCY_DEF,
  parameter int CNT_WIDTH   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dataa,
  input  logic [DATA_WIDTH-1:0] datab,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  done,
  output logic                  busy
);

  localparam logic signed [9:0] EXP_MAX = 10'(2 * BIAS + 1);

  logic fire;
  logic accept;

  assign accept = clk_en && start && !busy;

  op_timer #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clk_en(clk_en),
    .start (start),
    .max   (CNT_WIDTH'(ADD_LATENCY)),
    .busy  (busy),
    .done  (done),
    .fire  (fire)
  );

  // Highest set bit position expressed as a left-shift distance.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) lzc27 = 5'(26 - i);
    end
  endfunction

  // n holds 1.xxx in n[26:3] with guard n[2], round n[1], sticky n[0].
  function automatic logic [31:0] round_pack(input logic              sign,
                                             input logic signed [9:0] exp,
                                             input logic [26:0]       n);
    logic              rnd;
    logic [24:0]       m;
    logic signed [9:0] e;
    logic [22:0]       frac;
    rnd  = n[2] & (n[1] | n[0] | n[3]);
    m    = {1'b0, n[26:3]} + {24'd0, rnd};
    e    = m[24] ? exp + 10'sd1 : exp;
    frac = m[24] ? m[23:1] : m[22:0];
    if (e >= EXP_MAX) return POS_INF | {sign, 31'd0};
    if (e <= 10'sd0) return 32'h00000000;
    return {sign, e[7:0], frac};
  endfunction

  // ---- Stage 1: unpack, classify, order by magnitude, resolve specials ----
  fp32_t       fa, fb, big, sml;
  fp_class_e   ca, cb;
  logic [30:0] mag_a, mag_b;
  logic        spec_s0;
  logic [31:0] spec_val_s0;

  always_comb begin
    fa          = dataa;
    fb          = datab;
    ca          = fp_classify(fa);
    cb          = fp_classify(fb);
    mag_a       = (ca == ZERO) ? 31'd0 : {fa.exp, fa.mant};
    mag_b       = (cb == ZERO) ? 31'd0 : {fb.exp, fb.mant};
    big         = (mag_b > mag_a) ? fb : fa;
    sml         = (mag_b > mag_a) ? fa : fb;
    spec_s0     = 1'b1;
    spec_val_s0 = 32'h00000000;
    if (ca == NAN || cb == NAN) begin
      spec_val_s0 = QNAN;
    end else if (ca == INF && cb == INF) begin
      spec_val_s0 = (fa.sign == fb.sign) ? fa : QNAN;
    end else if (ca == INF) begin
      spec_val_s0 = fa;
    end else if (cb == INF) begin
      spec_val_s0 = fb;
    end else if (ca == ZERO && cb == ZERO) begin
      spec_val_s0 = {fa.sign & fb.sign, 31'd0};
    end else if (ca == ZERO) begin
      spec_val_s0 = fb;
    end else if (cb == ZERO) begin
      spec_val_s0 = fa;
    end else begin
      spec_s0 = 1'b0;
    end
  end

  logic        vld_p1, sign_a_p1, sign_b_p1, spec_p1;
  logic [7:0]  exp_a_p1, exp_b_p1;
  logic [22:0] man_a_p1, man_b_p1;
  logic [31:0] spec_val_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      sign_a_p1   <= 1'b0;
      sign_b_p1   <= 1'b0;
      exp_a_p1    <= '0;
      exp_b_p1    <= '0;
      man_a_p1    <= '0;
      man_b_p1    <= '0;
      spec_p1     <= 1'b0;
      spec_val_p1 <= '0;
    end else if (clk_en) begin
      vld_p1 <= accept;
      if (accept) begin
        sign_a_p1   <= big.sign;
        sign_b_p1   <= sml.sign;
        exp_a_p1    <= big.exp;
        exp_b_p1    <= sml.exp;
        man_a_p1    <= big.mant;
        man_b_p1    <= sml.mant;
        spec_p1     <= spec_s0;
        spec_val_p1 <= spec_val_s0;
      end
    end
  end

  // ---- Stage 2: align the smaller operand with guard/round/sticky ----
  logic [7:0]  ediff;
  logic [4:0]  shamt;
  logic [26:0] ext_b, shr_b;
  logic        lost_b;

  always_comb begin
    ediff  = exp_a_p1 - exp_b_p1;
    shamt  = (ediff > 8'd27) ? 5'd27 : ediff[4:0];
    ext_b  = {1'b1, man_b_p1, 3'b000};
    shr_b  = ext_b >> shamt;
    // Any bit pushed past the sticky position still counts for rounding.
    lost_b = |(ext_b & ~({27{1'b1}} << shamt));
  end

  logic        vld_p2, sign_p2, sub_p2, spec_p2;
  logic [7:0]  exp_p2;
  logic [26:0] man_a_p2, man_b_p2;
  logic [31:0] spec_val_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2      <= 1'b0;
      sign_p2     <= 1'b0;
      sub_p2      <= 1'b0;
      spec_p2     <= 1'b0;
      exp_p2      <= '0;
      man_a_p2    <= '0;
      man_b_p2    <= '0;
      spec_val_p2 <= '0;
    end else if (clk_en) begin
      vld_p2      <= vld_p1;
      sign_p2     <= sign_a_p1;
      sub_p2      <= sign_a_p1 ^ sign_b_p1;
      spec_p2     <= spec_p1;
      exp_p2      <= exp_a_p1;
      man_a_p2    <= {1'b1, man_a_p1, 3'b000};
      man_b_p2    <= {shr_b[26:1], shr_b[0] | lost_b};
      spec_val_p2 <= spec_val_p1;
    end
  end

  // ---- Stage 3: magnitude add/subtract (A >= B, so never negative) ----
  logic        vld_p3, sign_p3, spec_p3;
  logic [7:0]  exp_p3;
  logic [27:0] sum_p3;
  logic [31:0] spec_val_p3;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p3      <= 1'b0;
      sign_p3     <= 1'b0;
      spec_p3     <= 1'b0;
      exp_p3      <= '0;
      sum_p3      <= '0;
      spec_val_p3 <= '0;
    end else if (clk_en) begin
      vld_p3      <= vld_p2;
      sign_p3     <= sign_p2;
      spec_p3     <= spec_p2;
      exp_p3      <= exp_p2;
      sum_p3      <= sub_p2 ? ({1'b0, man_a_p2} - {1'b0, man_b_p2})
                            : ({1'b0, man_a_p2} + {1'b0, man_b_p2});
      spec_val_p3 <= spec_val_p2;
    end
  end

  // ---- Stage 4: normalise and adjust exponent ----
  logic [4:0]        lz;
  logic [26:0]       norm_s4;
  logic signed [9:0] exp_s4;

  always_comb begin
    lz = lzc27(sum_p3[26:0]);
    if (sum_p3[27]) begin
      norm_s4 = {sum_p3[27:2], sum_p3[1] | sum_p3[0]};
      exp_s4  = $signed({2'b00, exp_p3}) + 10'sd1;
    end else begin
      norm_s4 = sum_p3[26:0] << lz;
      exp_s4  = $signed({2'b00, exp_p3}) - $signed({5'b00000, lz});
    end
  end

  logic              vld_p4, sign_p4, zero_p4, spec_p4;
  logic signed [9:0] exp_p4;
  logic [26:0]       norm_p4;
  logic [31:0]       spec_val_p4;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p4      <= 1'b0;
      sign_p4     <= 1'b0;
      zero_p4     <= 1'b0;
      spec_p4     <= 1'b0;
      exp_p4      <= '0;
      norm_p4     <= '0;
      spec_val_p4 <= '0;
    end else if (clk_en) begin
      vld_p4      <= vld_p3;
      sign_p4     <= sign_p3;
      zero_p4     <= (sum_p3 == 28'd0);
      spec_p4     <= spec_p3;
      exp_p4      <= exp_s4;
      norm_p4     <= norm_s4;
      spec_val_p4 <= spec_val_p3;
    end
  end

  // ---- Stage 5: round, pack, special override; written only on completion ----
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
    end else if (fire && vld_p4) begin
      result <= spec_p4 ? spec_val_p4
                        : (zero_p4 ? 32'h00000000 : round_pack(sign_p4, exp_p4, norm_p4));
    end
  end

endmodule

// File: tb/tb_fp32_add_timed.sv
module tb_fp32_add_timed;

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;
  logic        done;
  logic        busy;

  int total = 0;
  int bad   = 0;

  fp32_add_timed dut (
    .clk   (clk),
    .rst   (rst),
    .clk_en(clk_en),
    .start (start),
    .dataa (dataa),
    .datab (datab),
    .result(result),
    .done  (done),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    string       nm;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", nm, act, expv);
    end
  endtask

  // Start an operation now and follow it to its done cycle; returns with done high.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] y, input string nm);
    dataa  = a;
    datab  = b;
    start  = 1'b1;
    clk_en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      start = 1'b0;
      if (k < 5) check({nm, "_busy"}, {30'd0, busy, done}, 32'h2);
      else       check({nm, "_done"}, {30'd0, busy, done}, 32'h1);
    end
    check({nm, "_result"}, result, y);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vecs.push_back('{32'h3F800000, 32'h40000000, 32'h40400000, "one_plus_two"});
    vecs.push_back('{32'h3FC00000, 32'hBFC00000, 32'h00000000, "cancel"});
    vecs.push_back('{32'h3F800000, 32'h33800000, 32'h3F800000, "tie_even"});
    vecs.push_back('{32'h3F800000, 32'h33800001, 32'h3F800001, "above_tie"});
    vecs.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, "ovf"});
    vecs.push_back('{32'h7F7FFFFF, 32'h73000000, 32'h7F800000, "rnd_ovf"});
    vecs.push_back('{32'h7F800000, 32'hFF800000, 32'h7FC00000, "inf_minus_inf"});
    vecs.push_back('{32'h7FC00001, 32'h3F800000, 32'h7FC00000, "nan_in"});
    vecs.push_back('{32'hFF800000, 32'h3F800000, 32'hFF800000, "inf_fin"});
    vecs.push_back('{32'h00000000, 32'h80000000, 32'h00000000, "pz_nz"});
    vecs.push_back('{32'h80000000, 32'h80000000, 32'h80000000, "nz_nz"});
    vecs.push_back('{32'h00000001, 32'h3F800000, 32'h3F800000, "sub_flush"});
    vecs.push_back('{32'h80000001, 32'h80000000, 32'h80000000, "neg_sub_flush"});
    vecs.push_back('{32'hBF000000, 32'h3F800000, 32'h3F000000, "swap_sub"});
    vecs.push_back('{32'hC0000000, 32'h3F800000, 32'hBF800000, "neg_res"});
    vecs.push_back('{32'h00C00000, 32'h80800000, 32'h00000000, "underflow"});
    vecs.push_back('{32'h4B800000, 32'h00800000, 32'h4B800000, "far_apart"});
    vecs.push_back('{32'h40A00000, 32'hC0400000, 32'h40000000, "five_m_three"});

    rst    = 1'b1;
    clk_en = 1'b1;
    start  = 1'b0;
    dataa  = '0;
    datab  = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_result", result, 32'h00000000);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].nm);
      tick();
      check({vecs[i].nm, "_clear"}, {30'd0, busy, done}, 32'h0);
      check({vecs[i].nm, "_hold"}, result, vecs[i].y);
    end

    // Stall for three cycles after E2, with a start attempt while busy.
    dataa  = 32'h3F800000;
    datab  = 32'h40000000;
    start  = 1'b1;
    clk_en = 1'b1;
    tick();
    check("stall_e0", {30'd0, busy, done}, 32'h2);
    dataa = 32'h40A00000;
    datab = 32'h40A00000;
    tick();
    start = 1'b0;
    check("stall_e1", {30'd0, busy, done}, 32'h2);
    tick();
    check("stall_e2", {30'd0, busy, done}, 32'h2);
    clk_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_frozen", {30'd0, busy, done}, 32'h2);
    end
    clk_en = 1'b1;
    tick();
    check("stall_e3", {30'd0, busy, done}, 32'h2);
    tick();
    check("stall_done", {30'd0, busy, done}, 32'h1);
    check("stall_result", result, 32'h40400000);
    clk_en = 1'b0;
    tick();
    check("done_clears_disabled", {30'd0, busy, done}, 32'h0);
    check("stall_hold", result, 32'h40400000);
    clk_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("ignored_start_idle", {30'd0, busy, done}, 32'h0);
    end
    check("ignored_start_result", result, 32'h40400000);

    // Reset mid-operation aborts it.
    dataa = 32'h3F800000;
    datab = 32'h40000000;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_state", {30'd0, busy, done}, 32'h0);
    check("abort_result", result, 32'h00000000);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("abort_no_done", {30'd0, busy, done}, 32'h0);
    end
    run_op(32'h40A00000, 32'hC0400000, 32'h40000000, "after_abort");
    tick();
    check("after_abort_clear", {30'd0, busy, done}, 32'h0);

    // Back-to-back: second start issued in the first one's done cycle.
    run_op(32'h3F800000, 32'h40000000, 32'h40400000, "b2b_first");
    run_op(32'h40A00000, 32'hC0400000, 32'h40000000, "b2b_second");
    tick();
    check("b2b_clear", {30'd0, busy, done}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
